control_multiciclo: RTL and testbench

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

---
 rtl/control_pkg.sv | 61 ++++++
 rtl/decod_opcode.sv | 32 +++
 rtl/control_multiciclo.sv | 161 ++++++++++++++++
 tb/tb_control_multiciclo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
//==============================================================================
// Module      : control_pkg
// Description : Shared types and encodings for the multicycle control unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_LUI     = 3'd0,
        C_RALU    = 3'd1,
        C_IALU    = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_BRANCH  = 3'd5,
        C_ILLEGAL = 3'd6
    } instr_class_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] MUXB_IMM_EX = 2'b00;
    localparam logic [1:0] MUXB_IMM_SW = 2'b01;
    localparam logic [1:0] MUXB_DOB    = 2'b10;

    localparam logic [1:0] MUXC_LUI = 2'b00;
    localparam logic [1:0] MUXC_ALU = 2'b01;
    localparam logic [1:0] MUXC_MEM = 2'b10;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    function automatic logic branch_legal(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE);
    endfunction

    // beq is taken on a zero result, bne on a non-zero result
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return (f3 == F3_BEQ) ? zero : ~zero;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decod_opcode.sv
//==============================================================================
// Module      : decod_opcode
// Description : Combinational opcode classifier with illegal-opcode flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decod_opcode
    import control_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t iclass,
    output logic         illegal
);

    always_comb begin
        iclass = C_ILLEGAL;
        case (opcode)
            OP_LUI:    iclass = C_LUI;
            OP_RTYPE:  iclass = C_RALU;
            OP_ITYPE:  iclass = C_IALU;
            OP_LOAD:   iclass = C_LOAD;
            OP_STORE:  iclass = C_STORE;
            OP_BRANCH: iclass = C_BRANCH;
            default:   iclass = C_ILLEGAL;
        endcase
        illegal = (iclass == C_ILLEGAL);
    end

endmodule

`default_nettype wire

// File: rtl/control_multiciclo.sv
//==============================================================================
// Module      : control_multiciclo
// Description : Multicycle RISC-V subset control FSM. Define MEM_TIMEOUT_EN
//               to trap when a MEM access waits TIMEOUT cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_multiciclo
    import control_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       cero,
    input  logic       instr_valid,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       pc_src,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] s_mux_b,
    output logic [1:0] s_mux_c,
    output logic       control_alu,
    output logic       instr_done,
    output logic       trap,
    output logic [2:0] state
);

    state_t       state_q;
    state_t       state_next;
    instr_class_t iclass;
    logic         illegal;
    logic         br_ok;
    logic         br_taken;
    logic         mem_timeout;

    decod_opcode u_decod (
        .opcode  (opcode),
        .iclass  (iclass),
        .illegal (illegal)
    );

    assign br_ok    = branch_legal(funct3);
    assign br_taken = branch_taken(funct3, cero);
    assign state    = state_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts wait cycles of the current MEM visit; any other state clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state_q == S_MEM && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign mem_timeout = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_FETCH;
        else
            state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_FETCH:  if (instr_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (illegal)              state_next = S_TRAP;
                else if (iclass == C_LUI) state_next = S_WB;
                else                      state_next = S_EXEC;
            end
            S_EXEC: begin
                case (iclass)
                    C_RALU, C_IALU:  state_next = S_WB;
                    C_LOAD, C_STORE: state_next = S_MEM;
                    C_BRANCH:        state_next = br_ok ? S_FETCH : S_TRAP;
                    default:         state_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready)        state_next = (iclass == C_LOAD) ? S_WB : S_FETCH;
                else if (mem_timeout) state_next = S_TRAP;
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr       = 1'b0;
        pc_src      = 1'b0;
        ir_wr       = 1'b0;
        reg_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        s_mux_b     = MUXB_IMM_EX;
        s_mux_c     = MUXC_LUI;
        control_alu = ALU_ADD;
        instr_done  = 1'b0;
        trap        = 1'b0;
        case (state_q)
            // Gated so a valid instruction cannot load the IR while held in reset
            S_FETCH: ir_wr = instr_valid & rst_n;
            S_EXEC: begin
                if (iclass == C_BRANCH || (iclass == C_RALU && funct7_5))
                    control_alu = ALU_SUB;
                case (iclass)
                    C_RALU, C_BRANCH: s_mux_b = MUXB_DOB;
                    C_STORE:          s_mux_b = MUXB_IMM_SW;
                    default:          s_mux_b = MUXB_IMM_EX;
                endcase
                if (iclass == C_BRANCH && br_ok) begin
                    pc_wr      = 1'b1;
                    pc_src     = br_taken;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                mem_rd = (iclass == C_LOAD);
                mem_wr = (iclass == C_STORE);
                if (iclass == C_STORE && mem_ready) begin
                    pc_wr      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
                case (iclass)
                    C_LUI:   s_mux_c = MUXC_LUI;
                    C_LOAD:  s_mux_c = MUXC_MEM;
                    default: s_mux_c = MUXC_ALU;
                endcase
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_multiciclo.sv
//==============================================================================
// Module      : tb_control_multiciclo
// Description : Scoreboard bench for control_multiciclo with a latency model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, cero, instr_valid, mem_ready;
    logic       pc_wr, pc_src, ir_wr, reg_wr, mem_rd, mem_wr;
    logic [1:0] s_mux_b, s_mux_c;
    logic       control_alu, instr_done, trap;
    logic [2:0] state;

    int vectors    = 0;
    int miscompares = 0;

    control_multiciclo #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .cero(cero), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .s_mux_b(s_mux_b),
        .s_mux_c(s_mux_c), .control_alu(control_alu), .instr_done(instr_done),
        .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       is_trap;
        int       lat;       // cycles from first FETCH cycle to retire/trap, inclusive
        bit       pc_src;
        bit       reg_wr;
        bit [1:0] mux_c;
        int       n_rd;
        int       n_wr;
        bit       has_exec;
        int       exec_cnt;
        bit       alu;
        bit [1:0] mux_b;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: instruction timing and control values straight from the ISA rules
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input bit f75, input bit z, input int fw, input int mw);
        exp_t e;
        e.is_trap = 0; e.lat = 0; e.pc_src = 0; e.reg_wr = 0; e.mux_c = 2'b00;
        e.n_rd = 0; e.n_wr = 0; e.has_exec = 1; e.exec_cnt = fw + 3;
        e.alu = 0; e.mux_b = 2'b00;
        case (op)
            7'b0110111: begin e.lat = fw + 3; e.reg_wr = 1; e.mux_c = 2'b00; e.has_exec = 0; end
            7'b0110011: begin e.lat = fw + 4; e.reg_wr = 1; e.mux_c = 2'b01; e.alu = f75; e.mux_b = 2'b10; end
            7'b0010011: begin e.lat = fw + 4; e.reg_wr = 1; e.mux_c = 2'b01; end
            7'b0000011: begin e.lat = fw + 5 + mw; e.reg_wr = 1; e.mux_c = 2'b10; e.n_rd = mw + 1; end
            7'b0100011: begin e.lat = fw + 4 + mw; e.n_wr = mw + 1; e.mux_b = 2'b01; end
            7'b1100011: begin
                e.alu = 1; e.mux_b = 2'b10;
                if (f3 == 3'b000)      begin e.lat = fw + 3; e.pc_src = z;  end
                else if (f3 == 3'b001) begin e.lat = fw + 3; e.pc_src = !z; end
                else                   begin e.lat = fw + 4; e.is_trap = 1; end
            end
            default: begin e.lat = fw + 3; e.is_trap = 1; e.has_exec = 0; end
        endcase
        return e;
    endfunction

    // Called just after a rising edge; DUT restarts in FETCH on the next cycle
    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_trap", trap, 0);
        check("rst_strobes", {pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, instr_done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input exp_t e, input int fw, input int mw);
        for (int t = 0; t < e.lat; t++) begin
            instr_valid = (t >= fw);
            mem_ready   = (t >= fw + 3 + mw);
            @(posedge clk); #1;
        end
        if (e.is_trap) begin
            instr_valid = 1'b1;
            mem_ready   = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            do_reset();
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit f75,
                             input bit z, input int fw, input int mw);
        exp_t e;
        e = model(op, f3, f75, z, fw, mw);
        q.push_back(e);
        opcode = op; funct3 = f3; funct7_5 = f75; cero = z;
        drive(e, fw, mw);
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'b0110111 || op == 7'b0110011 || op == 7'b0010011 ||
               op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // Monitor: pops an expectation whenever the DUT retires or traps
    int cnt = 0, nrd = 0, nwr = 0;
    bit trap_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cnt = 0; nrd = 0; nwr = 0; trap_seen = 0;
        end else if (trap_seen) begin
            check("trap_sticky", trap, 1);
            check("trap_quiet", {pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, instr_done}, 0);
        end else begin
            cnt++;
            nrd += int'(mem_rd);
            nwr += int'(mem_wr);
            check("rd_wr_excl", int'(mem_rd & mem_wr), 0);
            check("reg_memwr_excl", int'(reg_wr & mem_wr), 0);
            if (q.size() > 0 && q[0].has_exec && cnt == q[0].exec_cnt) begin
                check("exec_alu", control_alu, q[0].alu);
                check("exec_mux_b", s_mux_b, q[0].mux_b);
            end
            if (instr_done || trap) begin
                if (q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("is_trap", trap, e.is_trap);
                    check("latency", cnt, e.lat);
                    if (!e.is_trap) begin
                        check("pc_wr", pc_wr, 1);
                        check("pc_src", pc_src, e.pc_src);
                        check("reg_wr", reg_wr, e.reg_wr);
                        if (e.reg_wr) check("s_mux_c", s_mux_c, e.mux_c);
                        check("mem_rd_cycles", nrd, e.n_rd);
                        check("mem_wr_cycles", nwr, e.n_wr);
                    end
                end
                if (trap) trap_seen = 1;
                cnt = 0; nrd = 0; nwr = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int sel, fw, mw;
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 0; cero = 0;
        instr_valid = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed cases
        run_instr(7'b0110011, 3'b000, 0, 0, 0, 0);   // add
        run_instr(7'b1100011, 3'b001, 0, 0, 0, 0);   // bne taken
        run_instr(7'b1100011, 3'b001, 0, 1, 0, 0);   // bne not taken
        run_instr(7'b0000011, 3'b010, 0, 0, 0, 3);   // lw with 3 wait cycles
        run_instr(7'b0110111, 3'b000, 0, 0, 0, 0);   // lui
        run_instr(7'b1111111, 3'b000, 0, 0, 0, 0);   // illegal opcode
        run_instr(7'b1100011, 3'b101, 0, 0, 0, 0);   // branch, bad funct3

        // Store interrupted by reset while waiting in MEM
        opcode = 7'b0100011; funct3 = 3'b010; instr_valid = 1; mem_ready = 0;
        repeat (4) @(posedge clk);
        #1;
        check("midmem_wr_before", mem_wr, 1);
        rst_n = 1'b0;
        #1;
        check("midmem_wr_dropped", mem_wr, 0);
        check("midmem_state", state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef MEM_TIMEOUT_EN
        begin
            exp_t e;
            run_instr(7'b0100011, 3'b010, 0, 0, 0, 14);   // ready on the 15th MEM cycle
            e = model(7'b0000011, 3'b010, 0, 0, 0, 0);
            e.is_trap = 1; e.lat = 3 + 15 + 1;
            q.push_back(e);
            opcode = 7'b0000011; funct3 = 3'b010;
            drive(e, 0, 1000);
        end
`endif

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            fw  = $urandom_range(0, 3);
            mw  = $urandom_range(0, 5);
            f3  = 3'($urandom_range(0, 7));
            case (sel)
                0: op = 7'b0110111;
                1, 7: op = 7'b0110011;
                2: op = 7'b0010011;
                3, 9: op = 7'b0000011;
                4: op = 7'b0100011;
                5, 6: begin
                    op = 7'b1100011;
                    f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7))
                                                     : 3'($urandom_range(0, 1));
                end
                default: begin
                    op = 7'($urandom_range(0, 127));
                    while (is_legal(op)) op = 7'($urandom_range(0, 127));
                end
            endcase
            run_instr(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fw, mw);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
